rename_regfile: RTL

- Architectural register file plus per-register rename-tag table for the dual-issue out-of-order core.
- Sits between the decoder/dispatcher and the reorder buffer.
- Dispatcher side: supplies operand value-or-tag for both instructions of a dispatch pair, and records new destination tags.
- ROB side: consumes the commit port and retires values into architectural state.
- Branch-mispredict clear drops all pending renames.

---
 rtl/rename_regfile.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/rename_regfile.sv
// rename_regfile: architectural register file with a per-register rename tag.
// Operand reads give either a ready value or the ROB tag of the pending
// producer, with commit bypass and intra-pair dependency forwarding.
// Commits retire values into architectural state, renames record new
// producers, and a mispredict clear drops every pending rename.
module rename_regfile #(
  parameter int DATA_W  = 32,
  parameter int REG_SEL = 5,
  parameter int ROB_SEL = 3,
  parameter int TAG_W   = ROB_SEL + 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               rdy,
  input  logic               clear,
  input  logic               stall,
  input  logic [REG_SEL-1:0] rs1_1,
  input  logic [REG_SEL-1:0] rs2_1,
  input  logic [REG_SEL-1:0] rs1_2,
  input  logic [REG_SEL-1:0] rs2_2,
  output logic [TAG_W-1:0]   tag1_1,
  output logic [TAG_W-1:0]   tag2_1,
  output logic [TAG_W-1:0]   tag1_2,
  output logic [TAG_W-1:0]   tag2_2,
  output logic [DATA_W-1:0]  data1_1,
  output logic [DATA_W-1:0]  data2_1,
  output logic [DATA_W-1:0]  data1_2,
  output logic [DATA_W-1:0]  data2_2,
  input  logic               dpw_en1,
  input  logic               dpw_wrrd1,
  input  logic [REG_SEL-1:0] dpw_addr1,
  input  logic               dpw_en2,
  input  logic               dpw_wrrd2,
  input  logic [REG_SEL-1:0] dpw_addr2,
  input  logic [ROB_SEL-1:0] alloc_ptr_1,
  input  logic [ROB_SEL-1:0] alloc_ptr_2,
  input  logic               com_wrrd,
  input  logic [REG_SEL-1:0] com_addr,
  input  logic [DATA_W-1:0]  com_data,
  input  logic [TAG_W-1:0]   com_tag
);

  localparam int NREG = 1 << REG_SEL;
  localparam logic [TAG_W-1:0]   TAG_FREE  = {1'b1, {ROB_SEL{1'b0}}};
  localparam logic [REG_SEL-1:0] REG_ZERO  = {REG_SEL{1'b0}};
  localparam logic [DATA_W-1:0]  DATA_ZERO = {DATA_W{1'b0}};

  logic [DATA_W-1:0] data_r [NREG];
  logic [TAG_W-1:0]  tag_r  [NREG];

  // Per-read-port lookup results packed as {tag, data}
  logic [TAG_W+DATA_W-1:0] rd11_s;
  logic [TAG_W+DATA_W-1:0] rd21_s;
  logic [TAG_W+DATA_W-1:0] rd12_s;
  logic [TAG_W+DATA_W-1:0] rd22_s;

  // Qualified write strobes
  logic com_we_s;
  logic ren1_s;
  logic ren2_s;

  // Architectural lookup of register r: x0, commit bypass, ready value, or pending tag.
  function automatic logic [TAG_W+DATA_W-1:0] lookup(
    input logic [REG_SEL-1:0] r,
    input logic [TAG_W-1:0]   t,
    input logic [DATA_W-1:0]  d
  );
    logic [TAG_W+DATA_W-1:0] res;
    if (r == REG_ZERO) begin
      res = {TAG_FREE, DATA_ZERO};
    end else if ((t != TAG_FREE) && com_wrrd && (com_addr == r) && (com_tag == t)) begin
      res = {TAG_FREE, com_data};
    end else if (t == TAG_FREE) begin
      res = {TAG_FREE, d};
    end else begin
      res = {t, DATA_ZERO};
    end
    return res;
  endfunction

  // Instruction 2 sees instruction 1's new tag when it reads the register instr 1 writes.
  function automatic logic [TAG_W+DATA_W-1:0] lookup_pair(
    input logic [REG_SEL-1:0] r,
    input logic [TAG_W-1:0]   t,
    input logic [DATA_W-1:0]  d
  );
    logic [TAG_W+DATA_W-1:0] res;
    if (dpw_en1 && dpw_wrrd1 && (dpw_addr1 == r) && (r != REG_ZERO)) begin
      res = {1'b0, alloc_ptr_1, DATA_ZERO};
    end else begin
      res = lookup(r, t, d);
    end
    return res;
  endfunction

  // Combinational operand reads for both instructions of the dispatch pair.
  always_comb begin
    rd11_s = lookup(rs1_1, tag_r[rs1_1], data_r[rs1_1]);
    rd21_s = lookup(rs2_1, tag_r[rs2_1], data_r[rs2_1]);
    rd12_s = lookup_pair(rs1_2, tag_r[rs1_2], data_r[rs1_2]);
    rd22_s = lookup_pair(rs2_2, tag_r[rs2_2], data_r[rs2_2]);
  end

  assign tag1_1  = rd11_s[TAG_W+DATA_W-1:DATA_W];
  assign data1_1 = rd11_s[DATA_W-1:0];
  assign tag2_1  = rd21_s[TAG_W+DATA_W-1:DATA_W];
  assign data2_1 = rd21_s[DATA_W-1:0];
  assign tag1_2  = rd12_s[TAG_W+DATA_W-1:DATA_W];
  assign data1_2 = rd12_s[DATA_W-1:0];
  assign tag2_2  = rd22_s[TAG_W+DATA_W-1:DATA_W];
  assign data2_2 = rd22_s[DATA_W-1:0];

  // Write strobes; x0 is never written or renamed.
  always_comb begin
    com_we_s = com_wrrd && (com_addr != REG_ZERO);
    ren1_s   = !clear && !stall && dpw_en1 && dpw_wrrd1 && (dpw_addr1 != REG_ZERO);
    ren2_s   = !clear && !stall && dpw_en2 && dpw_wrrd2 && (dpw_addr2 != REG_ZERO);
  end

  // State update: later assignments win, giving rename2 > rename1 > clear/commit-free.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) begin
        data_r[i] <= DATA_ZERO;
        tag_r[i]  <= TAG_FREE;
      end
    end else if (rdy) begin
      if (com_we_s) begin
        data_r[com_addr] <= com_data;
        if (tag_r[com_addr] == com_tag) begin
          tag_r[com_addr] <= TAG_FREE;
        end
      end
      if (clear) begin
        for (int i = 0; i < NREG; i++) begin
          tag_r[i] <= TAG_FREE;
        end
      end
      if (ren1_s) begin
        tag_r[dpw_addr1] <= {1'b0, alloc_ptr_1};
      end
      if (ren2_s) begin
        tag_r[dpw_addr2] <= {1'b0, alloc_ptr_2};
      end
    end
  end

endmodule
